// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - multiplexed seven-segment bus capture into packed BCD
// A digit commits once its one-hot (dig_en, seg_in) sample has been seen on STABLE_CYCLES+1 consecutive edges.
`timescale 1ns/1ps
module seg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_en,
  input  logic                err_clr,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                update,
  output logic                err
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {K_DIGIT, K_BLANK, K_INVALID} kind_e;

  logic [6:0]          s_seg_q;
  logic [DIGITS-1:0]   s_en_q;
  logic [CW-1:0]       run_cnt_q, run_cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                update_q, update_d;
  logic                err_q, err_d;

  logic [3:0] code_val;
  kind_e      code_kind;
  logic       en_onehot;
  logic       s_multi;
  logic       commit;
  logic       bad_pat;

  always_comb begin
    code_val  = 4'd0;
    code_kind = K_DIGIT;
    case (s_seg_q)
      7'b1111110: code_val = 4'd0;
      7'b0110000: code_val = 4'd1;
      7'b1101101: code_val = 4'd2;
      7'b1111001: code_val = 4'd3;
      7'b0110011: code_val = 4'd4;
      7'b1011011: code_val = 4'd5;
      7'b1011111: code_val = 4'd6;
      7'b1110000: code_val = 4'd7;
      7'b1111111: code_val = 4'd8;
      7'b1111011: code_val = 4'd9;
      7'b0000000: code_kind = K_BLANK;
      default:    code_kind = K_INVALID;
    endcase
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    commit    = 1'b0;
    bad_pat   = 1'b0;
    en_onehot = (dig_en != '0) && ((dig_en & (dig_en - DIGITS'(1))) == '0);
    s_multi   = (s_en_q & (s_en_q - DIGITS'(1))) != '0;

    // run_cnt counts edges on which the arriving sample matches the registered one
    if (!en_onehot || dig_en != s_en_q || seg_in != s_seg_q) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RUN_MAX) begin
      run_cnt_d = run_cnt_q + CW'(1);
      commit    = (run_cnt_d == RUN_MAX);
    end

    if (commit) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (s_en_q[i]) begin
          if (code_kind == K_DIGIT) begin
            if (!valid_q[i] || bcd_q[4*i +: 4] != code_val) update_d = 1'b1;
            bcd_d[4*i +: 4] = code_val;
            valid_d[i]      = 1'b1;
          end else begin
            if (valid_q[i]) update_d = 1'b1;
            valid_d[i] = 1'b0;
            bad_pat    = (code_kind == K_INVALID);
          end
        end
      end
    end

    if (s_multi || bad_pat) err_d = 1'b1;
    else if (err_clr)       err_d = 1'b0;
    else                    err_d = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg_q   <= '0;
      s_en_q    <= '0;
      run_cnt_q <= '0;
      bcd_q     <= '0;
      valid_q   <= '0;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s_seg_q   <= seg_in;
      s_en_q    <= dig_en;
      run_cnt_q <= run_cnt_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      err_q     <= err_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign err         = err_q;
endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - scoreboard bench for seg_capture
// Expected outputs come from a run-length model over the history of applied input samples.
`timescale 1ns/1ps
module tb_seg_capture;
  localparam int DIGITS = 4;
  localparam int S      = 4;
  localparam int HW     = DIGITS + 7;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_en;
  logic                err_clr;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_valid;
  logic                update;
  logic                err;

  seg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en), .err_clr(err_clr),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .update(update), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   valid;
    logic                upd;
    logic                err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_mis = 0;
  int   upd_seen = 0;

  logic [6:0]    pat [10];
  logic [HW-1:0] hist[$];
  logic [3:0]    m_bcd [DIGITS];
  logic [DIGITS-1:0] m_valid;
  logic          m_err;

  initial begin
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
    pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
    pat[8] = 7'b1111111; pat[9] = 7'b1111011;
  end

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    for (int i = 0; i < DIGITS; i++) m_bcd[i] = 4'd0;
    m_valid = '0;
    m_err   = 1'b0;
  endtask

  // A commit happens when the newest S+1 samples are one identical one-hot sample
  // and the sample before them differs, so a held pattern commits exactly once.
  task automatic model_edge(input logic [6:0] sg, input logic [DIGITS-1:0] en, input logic clr);
    logic [HW-1:0] cur, prv;
    int   n, idx, val;
    bit   run_ok, set_err, upd;
    exp_t e;
    cur = {en, sg};
    prv = hist[hist.size()-1];
    hist.push_back(cur);
    n = hist.size();
    set_err = ($countones(prv[HW-1:7]) > 1);
    upd = 1'b0;
    run_ok = ($countones(en) == 1) && (n >= S + 2);
    if (run_ok) begin
      for (int j = 1; j <= S; j++) if (hist[n-1-j] != cur) run_ok = 1'b0;
      if (hist[n-2-S] == cur) run_ok = 1'b0;
    end
    if (run_ok) begin
      idx = 0;
      for (int j = 0; j < DIGITS; j++) if (en[j]) idx = j;
      val = -1;
      for (int p = 0; p < 10; p++) if (pat[p] == sg) val = p;
      if (val >= 0) begin
        upd = !m_valid[idx] || (m_bcd[idx] != 4'(val));
        m_bcd[idx]   = 4'(val);
        m_valid[idx] = 1'b1;
      end else begin
        upd = m_valid[idx];
        m_valid[idx] = 1'b0;
        if (sg != 7'd0) set_err = 1'b1;
      end
    end
    if (set_err)  m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (hist.size() > S + 2) void'(hist.pop_front());
    for (int i = 0; i < DIGITS; i++) e.bcd[4*i +: 4] = m_bcd[i];
    e.valid = m_valid;
    e.upd   = upd;
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [6:0] sg, input logic [DIGITS-1:0] en, input logic clr);
    seg_in  = sg;
    dig_en  = en;
    err_clr = clr;
    @(posedge clk);
    #2;
    model_edge(sg, en, clr);
  endtask

  task automatic hold(input logic [6:0] sg, input logic [DIGITS-1:0] en, input int n);
    for (int k = 0; k < n; k++) step(sg, en, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_bcd", 32'(bcd_out), 32'd0);
    chk("async_rst_valid", 32'(digit_valid), 32'd0);
    chk("async_rst_update", 32'(update), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic scan();
    for (int d = 0; d < DIGITS; d++) hold(pat[d+1], DIGITS'(1) << d, 6);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (update) upd_seen++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_vec++;
        if ({bcd_out, digit_valid, update, err} !== mon_e) begin
          n_mis++;
          $display("FAIL cycle_check @%0t: got bcd=%h valid=%b upd=%b err=%b expected bcd=%h valid=%b upd=%b err=%b",
                   $time, bcd_out, digit_valid, update, err, mon_e.bcd, mon_e.valid, mon_e.upd, mon_e.err);
        end
      end
    end
  end

  initial begin
    logic [6:0]        r_sg;
    logic [DIGITS-1:0] r_en;
    int                r_k, r_len;
    rst = 1'b1; seg_in = '0; dig_en = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_bcd", 32'(bcd_out), 32'd0);
    chk("reset_valid", 32'(digit_valid), 32'd0);
    chk("reset_update", 32'(update), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    model_reset();
    hold(7'd0, '0, 2);

    hold(pat[5], 4'b0010, 6);
    hold(7'b1111001, 4'b0001, 2);
    do_reset();
    upd_seen = 0;
    hold(7'b1111001, 4'b0001, 7);
    chk("reset_release_upd_pulses", 32'(upd_seen), 32'd1);
    chk("reset_release_bcd0", 32'(bcd_out[3:0]), 32'd3);
    chk("reset_release_valid", 32'(digit_valid), 32'b0001);

    upd_seen = 0;
    hold(pat[1], 4'b0010, 4);
    hold(7'd0, '0, 3);
    chk("short_hold_upd", 32'(upd_seen), 32'd0);
    chk("short_hold_valid1", 32'(digit_valid[1]), 32'd0);

    upd_seen = 0;
    scan();
    chk("scan1_upd", 32'(upd_seen), 32'd4);
    upd_seen = 0;
    scan();
    chk("scan2_upd", 32'(upd_seen), 32'd0);
    chk("scan_bcd", 32'(bcd_out), 32'h4321);
    chk("scan_valid", 32'(digit_valid), 32'hf);

    hold(pat[7], 4'b0100, 6);
    upd_seen = 0;
    hold(7'd0, 4'b0100, 6);
    chk("blank_upd", 32'(upd_seen), 32'd1);
    chk("blank_valid2", 32'(digit_valid[2]), 32'd0);
    chk("blank_bcd2", 32'(bcd_out[11:8]), 32'd7);
    chk("blank_err", 32'(err), 32'd0);
    upd_seen = 0;
    hold(7'b1000001, 4'b0100, 6);
    chk("invalid_err", 32'(err), 32'd1);
    chk("invalid_upd", 32'(upd_seen), 32'd0);

    step(7'd0, '0, 1'b1);
    chk("errclr_pre", 32'(err), 32'd0);
    step(7'd0, 4'b0011, 1'b0);
    step(7'd0, '0, 1'b0);
    chk("multihot_err", 32'(err), 32'd1);
    step(7'd0, 4'b0011, 1'b0);
    step(7'd0, '0, 1'b1);
    chk("set_beats_clr", 32'(err), 32'd1);
    step(7'd0, '0, 1'b1);
    chk("lone_clr", 32'(err), 32'd0);

    upd_seen = 0;
    hold(pat[8], 4'b0001, 100);
    chk("sat_upd", 32'(upd_seen), 32'd1);
    chk("sat_bcd0", 32'(bcd_out[3:0]), 32'd8);

    for (int r = 0; r < 40; r++) begin
      r_k = $urandom_range(0, 9);
      if (r_k <= 6)      r_sg = pat[$urandom_range(0, 9)];
      else if (r_k == 7) r_sg = 7'd0;
      else               r_sg = 7'($urandom_range(0, 127));
      r_k = $urandom_range(0, 9);
      if (r_k <= 7)      r_en = DIGITS'(1) << $urandom_range(0, DIGITS-1);
      else if (r_k == 8) r_en = '0;
      else               r_en = DIGITS'($urandom_range(0, 15));
      r_len = $urandom_range(1, 8);
      for (int k = 0; k < r_len; k++) step(r_sg, r_en, ($urandom_range(0, 9) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
